serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 The block SHALL have parameter N, default 8, giving operand width in bits; legal range is N >= 2.
REQ-002 The block SHALL have parameter SIGNED, default 0; 0 selects unsigned comparison, 1 selects two's-complement comparison.
REQ-003 The block SHALL have port clk, input, 1 bit; the single clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit; requests a comparison, sampled on the rising edge of clk.
REQ-006 The block SHALL have port a, input, N bits; first operand, captured when start is accepted.
REQ-007 The block SHALL have port b, input, N bits; second operand, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1 bit; high while a comparison is in progress.
REQ-009 The block SHALL have port done, output, 1 bit; one-cycle pulse when a result becomes valid.
REQ-010 The block SHALL have ports greater, equal and lesser, outputs, 1 bit each; registered result flags for a>b, a==b and a<b.
REQ-011 The block SHALL have port bits_used, output, $clog2(N+1) bits; number of bit positions examined in the last comparison.

Function
REQ-012 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE (busy=0); an accepted start SHALL capture a and b, set the bit index to N-1 and enter SCAN.
REQ-014 start asserted while busy=1 SHALL be ignored, and the captured operands SHALL NOT change.
REQ-015 In SCAN, one bit pair SHALL be compared per cycle, starting at the MSB (index N-1) and moving toward the LSB; bits_used SHALL increment by 1 per SCAN cycle.
REQ-016 The first differing bit SHALL decide the result: unsigned, a_bit=1 SHALL give greater and a_bit=0 SHALL give lesser.
REQ-017 With SIGNED=1, a difference at index N-1 SHALL use inverted sense: a_bit=1 SHALL give lesser; differences at lower indices SHALL use the unsigned rule.
REQ-018 If no bit differs after index 0 is examined, the result SHALL be equal.
REQ-019 SCAN SHALL exit to DONE after the terminating bit (see REQ-027 and REQ-028); the state SHALL then pass DONE -> IDLE unless a start is accepted in DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, and greater, equal and lesser SHALL update in that same cycle with exactly one of them high.
REQ-021 Result flags and bits_used SHALL hold their values from DONE until the next DONE; they SHALL NOT change during SCAN.
REQ-022 busy SHALL be 1 in SCAN only.
REQ-023 A start accepted in DONE SHALL enter SCAN on the next cycle, giving back-to-back operation without an IDLE cycle.

Reset
REQ-024 While rst_n=0, the state SHALL be IDLE and busy, done, greater, equal, lesser and bits_used SHALL all be 0, regardless of clk.
REQ-025 Reset asserted during SCAN or DONE SHALL abort the comparison, and no done pulse SHALL be produced for it.
REQ-026 After rst_n deasserts, the first rising edge of clk SHALL be able to accept start.

Configuration
REQ-027 When macro SERIAL_CMP_EARLY_EXIT_EN is defined, SCAN SHALL terminate on the first differing bit, and bits_used SHALL equal (N - index of first difference), or N when the operands are equal.
REQ-028 When SERIAL_CMP_EARLY_EXIT_EN is not defined, SCAN SHALL always last N cycles, done SHALL occur N+1 cycles after start is accepted, bits_used SHALL equal N, and the result SHALL be latched at the first difference.

Verification
REQ-029 N=3, SIGNED=0, early exit defined: a=000, b=111 -> lesser=1, bits_used=1, done 2 cycles after start.
REQ-030 N=3, SIGNED=0: a=101, b=101 -> equal=1, bits_used=3, done 4 cycles after start, with and without the macro.
REQ-031 N=3, a=011, b=100: SIGNED=0 -> lesser=1; SIGNED=1 -> greater=1.
REQ-032 N=3, macro undefined: a=001, b=000 -> greater=1, bits_used=3; a second start pulsed mid-SCAN -> ignored, with a single done pulse.
REQ-033 N=3: start a=010, b=010, then a start accepted in the DONE cycle with a=111, b=110 -> second done returns greater=1, with no IDLE gap.
REQ-034 Reset mid-SCAN: rst_n=0 for 1 cycle -> all outputs 0, no done pulse, and the next start completes normally.

Source files
------------

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: scans operand pairs MSB-first, one bit per cycle.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the scan at the first differing bit.
module serial_comparator #(
    parameter int N      = 8,
    parameter int SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [N-1:0]           a,
    input  logic [N-1:0]           b,
    output logic                   busy,
    output logic                   done,
    output logic                   greater,
    output logic                   equal,
    output logic                   lesser,
    output logic [$clog2(N+1)-1:0] bits_used
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [IW-1:0]   idx;
    logic [CW-1:0]   cnt;
    logic            decided;
    logic            dec_gt;

    logic            accept;
    logic            a_bit;
    logic            b_bit;
    logic            new_diff;
    logic            msb_pos;
    logic            gt_bit;
    logic            fin_dec;
    logic            fin_gt;
    logic            last;

    // Only the first differing bit decides; the sign bit has inverted weight in signed mode.
    always_comb begin
        accept   = start && (state != SCAN);
        a_bit    = a_reg[idx];
        b_bit    = b_reg[idx];
        msb_pos  = (idx == IW'(N - 1));
        new_diff = !decided && (a_bit != b_bit);
        gt_bit   = ((SIGNED != 0) && msb_pos) ? b_bit : a_bit;
        fin_dec  = decided | new_diff;
        fin_gt   = new_diff ? gt_bit : dec_gt;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        last     = new_diff || (idx == '0);
`else
        last     = (idx == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (last)   state_next = DONE;
            DONE:    state_next = accept ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SCAN);
    assign done = (state == DONE);

    // Published flags and bits_used change only on the edge that enters DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            idx       <= '0;
            cnt       <= '0;
            decided   <= 1'b0;
            dec_gt    <= 1'b0;
            greater   <= 1'b0;
            equal     <= 1'b0;
            lesser    <= 1'b0;
            bits_used <= '0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            idx     <= IW'(N - 1);
            cnt     <= '0;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
        end else if (state == SCAN) begin
            cnt     <= cnt + CW'(1);
            decided <= fin_dec;
            dec_gt  <= fin_gt;
            if (last) begin
                greater   <= fin_dec && fin_gt;
                lesser    <= fin_dec && !fin_gt;
                equal     <= !fin_dec;
                bits_used <= cnt + CW'(1);
            end else begin
                idx <= idx - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (N=3), unsigned and signed instances side by side.
module tb_serial_comparator;

    localparam int N  = 3;
    localparam int CW = $clog2(N + 1);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;

    logic          u_busy, u_done, u_gt, u_eq, u_lt;
    logic [CW-1:0] u_bits;
    logic          s_busy, s_done, s_gt, s_eq, s_lt;
    logic [CW-1:0] s_bits;

    int checks = 0;
    int errors = 0;

    serial_comparator #(.N(N), .SIGNED(0)) u_uns (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(u_busy), .done(u_done), .greater(u_gt), .equal(u_eq),
        .lesser(u_lt), .bits_used(u_bits)
    );

    serial_comparator #(.N(N), .SIGNED(1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(s_busy), .done(s_done), .greater(s_gt), .equal(s_eq),
        .lesser(s_lt), .bits_used(s_bits)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Pulses start for one edge, then waits (bounded) for the unsigned instance's done.
    task automatic apply_stimulus(input logic [N-1:0] va, input logic [N-1:0] vb,
                                  output int latency);
        a     = va;
        b     = vb;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        latency = 1;
        while (!u_done && latency < 20) begin
            @(negedge clk);
            latency++;
        end
    endtask

    task automatic check_result(input string tag, input logic [2:0] u_exp, input logic [2:0] s_exp,
                                input int exp_bits, input int exp_lat, input int lat);
        check_output({tag, "_lat"}, lat, exp_lat);
        check_output({tag, "_done"}, int'({u_done, s_done}), 3);
        check_output({tag, "_uns_gel"}, int'({u_gt, u_eq, u_lt}), int'(u_exp));
        check_output({tag, "_sgn_gel"}, int'({s_gt, s_eq, s_lt}), int'(s_exp));
        check_output({tag, "_bits"}, int'(u_bits), exp_bits);
        check_output({tag, "_sbits"}, int'(s_bits), exp_bits);
    endtask

    initial begin
        int lat;
        int dones;

        // Reset state
        #2;
        check_output("rst_outputs", int'({u_busy, u_done, u_gt, u_eq, u_lt, u_bits}), 0);
        check_output("rst_outputs_s", int'({s_busy, s_done, s_gt, s_eq, s_lt, s_bits}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 000 vs 111: unsigned lesser, signed greater (0 > -1); MSB decides
        apply_stimulus(3'b000, 3'b111, lat);
        check_result("v000_111", 3'b001, 3'b100, EARLY ? 1 : 3, EARLY ? 2 : 4, lat);
        @(negedge clk);
        check_output("v000_111_pulse", int'({u_done, u_busy}), 0);

        // 101 vs 101: equal, full scan in both modes
        apply_stimulus(3'b101, 3'b101, lat);
        check_result("v101_101", 3'b010, 3'b010, 3, 4, lat);
        @(negedge clk);

        // 011 vs 100: unsigned lesser, signed greater (3 > -4)
        apply_stimulus(3'b011, 3'b100, lat);
        check_result("v011_100", 3'b001, 3'b100, EARLY ? 1 : 3, EARLY ? 2 : 4, lat);
        @(negedge clk);

        // 001 vs 000 with a second start mid-scan carrying operands that would flip the result
        a     = 3'b001;
        b     = 3'b000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("mid_busy", int'(u_busy), 1);
        a = 3'b000;
        b = 3'b111;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 2;
        while (!u_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_result("v001_000", 3'b100, 3'b100, 3, 4, lat);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (u_done) dones++;
        end
        check_output("mid_single_done", dones, 0);
        check_output("mid_idle_busy", int'(u_busy), 0);

        // Back-to-back: 010 vs 010 then a start accepted in the DONE cycle
        apply_stimulus(3'b010, 3'b010, lat);
        check_result("b2b_first", 3'b010, 3'b010, 3, 4, lat);
        a     = 3'b111;
        b     = 3'b110;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_no_gap", int'({u_busy, u_done}), 2);
        lat = 1;
        while (!u_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_result("b2b_second", 3'b100, 3'b100, 3, 4, lat);
        @(negedge clk);

        // Reset during SCAN aborts with no done pulse
        a     = 3'b000;
        b     = 3'b111;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_output("abort_outputs", int'({u_busy, u_done, u_gt, u_eq, u_lt, u_bits}), 0);
        check_output("abort_outputs_s", int'({s_busy, s_done, s_gt, s_eq, s_lt, s_bits}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (u_done || s_done) dones++;
        end
        check_output("abort_no_done", dones, 0);

        // 101 vs 011 after the abort: unsigned greater, signed lesser (-3 < 3)
        apply_stimulus(3'b101, 3'b011, lat);
        check_result("post_abort", 3'b100, 3'b001, EARLY ? 1 : 3, EARLY ? 2 : 4, lat);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
